// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: fixed 8-line, 16-byte-block geometry
// and the L1 controller state encoding.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [8:0]   lc3b_c_tag;
   typedef logic [2:0]   lc3b_c_index;
   typedef logic [3:0]   lc3b_c_offset;
   typedef logic [127:0] lc3b_c_block;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2
   } lc3b_cache_state;

endpackage

// File: rtl/l1_cache_array.sv
// cache_array: per-line valid/dirty/tag/data storage with a byte-enable
// word write port and a full-line load port. Ports: index_i selects line.
module cache_array
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  lc3b_c_index index_i,
   input  logic        we_i,
   input  logic [2:0]  word_i,
   input  logic [1:0]  wmask_i,
   input  lc3b_word    wdata_i,
   input  logic        load_i,
   input  lc3b_c_tag   load_tag_i,
   input  lc3b_c_block load_data_i,
   output logic        valid_o,
   output logic        dirty_o,
   output lc3b_c_tag   tag_o,
   output lc3b_c_block data_o
);

   logic [7:0]  valid_q;
   logic [7:0]  dirty_q;
   lc3b_c_tag   tag_q  [8];
   lc3b_c_block data_q [8];
   logic [6:0]  base;

   assign base    = {word_i, 4'b0000};
   assign valid_o = valid_q[index_i];
   assign dirty_o = dirty_q[index_i];
   assign tag_o   = tag_q[index_i];
   assign data_o  = data_q[index_i];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (load_i) begin
         valid_q[index_i] <= 1'b1;
         dirty_q[index_i] <= 1'b0;
      end else if (we_i) begin
         // An empty mask still marks the line dirty.
         dirty_q[index_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (load_i) begin
         tag_q[index_i]  <= load_tag_i;
         data_q[index_i] <= load_data_i;
      end else if (we_i) begin
         if (wmask_i[0])
            data_q[index_i][base +: 8] <= wdata_i[7:0];
         if (wmask_i[1])
            data_q[index_i][base + 7'd8 +: 8] <= wdata_i[15:8];
      end
   end

endmodule

// File: rtl/l1_cache.sv
// l1_cache: direct-mapped write-back write-allocate L1 for LC-3b.
// CPU side: mem_* request/response. Memory side: pmem_* line transfers.
module l1_cache
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_wmask,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        mem_resp,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [15:0] pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic        pmem_resp
);

   lc3b_cache_state state_q, state_d;
   lc3b_c_tag       miss_tag_q, miss_tag_d;
   lc3b_c_index     miss_idx_q, miss_idx_d;

   lc3b_c_tag   req_tag;
   lc3b_c_index req_idx;
   logic [2:0]  req_word;
   logic        req;
   logic        hit;

   lc3b_c_index arr_idx;
   logic        arr_we;
   logic        arr_load;
   logic        line_valid;
   logic        line_dirty;
   lc3b_c_tag   line_tag;
   lc3b_c_block line_data;

   assign req_tag  = mem_address[15:7];
   assign req_idx  = mem_address[6:4];
   assign req_word = mem_address[3:1];
   assign req      = mem_read | mem_write;
   assign hit      = line_valid && (line_tag == req_tag);

   // The miss line is latched so pmem signals stay stable even if the
   // CPU changes or withdraws its request mid-transfer.
   assign arr_idx = (state_q == IDLE) ? req_idx : miss_idx_q;

   assign mem_rdata  = line_data[{req_word, 4'b0000} +: 16];
   assign pmem_wdata = line_data;

   cache_array u_array (
      .clk         (clk),
      .rst_n       (rst_n),
      .index_i     (arr_idx),
      .we_i        (arr_we),
      .word_i      (req_word),
      .wmask_i     (mem_wmask),
      .wdata_i     (mem_wdata),
      .load_i      (arr_load),
      .load_tag_i  (miss_tag_q),
      .load_data_i (pmem_rdata),
      .valid_o     (line_valid),
      .dirty_o     (line_dirty),
      .tag_o       (line_tag),
      .data_o      (line_data)
   );

   always_comb begin
      state_d      = state_q;
      miss_tag_d   = miss_tag_q;
      miss_idx_d   = miss_idx_q;
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'h0000;
      arr_we       = 1'b0;
      arr_load     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  mem_resp = 1'b1;
                  arr_we   = mem_write;
               end else begin
                  miss_tag_d = req_tag;
                  miss_idx_d = req_idx;
                  state_d    = (line_valid && line_dirty) ? WRITEBACK : FILL;
               end
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {line_tag, miss_idx_q, 4'b0000};
            if (pmem_resp)
               state_d = req ? FILL : IDLE;
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {miss_tag_q, miss_idx_q, 4'b0000};
            if (pmem_resp) begin
               arr_load = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         miss_tag_q <= '0;
         miss_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         miss_tag_q <= miss_tag_d;
         miss_idx_q <= miss_idx_d;
      end
   end

endmodule
